seq_key_lock: RTL and testbench

Parametrised multi-step combination lock with wildcard key matching, a power-on re-arm delay, and a failed-attempt lockout. It accepts a sequence of `STEPS` keys on a valid strobe and checks each one against a per-step pattern/mask pair. Once the whole sequence matches, it asserts a sticky `unlock` that is cleared by an explicit relock. It sits in front of privileged control paths in the sandbox designs and is the formal-friendly successor to the single-key latch and the fixed two-cycle delayed-reset register.

---
 rtl/seq_key_lock.sv | 159 +++++++++++++++
 tb/tb_seq_key_lock.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_key_lock.sv
// seq_key_lock: multi-step combination lock with wildcard key matching.
// Ports:
//   clk, rstn (sync, active-low)
//   key_valid, key, relock (in)
//   ready, unlock, step, fail_cnt, locked_out (out)
// Lockout feature: define SEQ_KEY_LOCK_LOCKOUT_EN.
module seq_key_lock #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STEPS       = 3,
  parameter logic [STEPS*WIDTH-1:0] PATTERN =
    {8'h00, 8'h3C, 8'h84},
  parameter logic [STEPS*WIDTH-1:0] MASK =
    {8'h0F, 8'hFF, 8'hA5},
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCKOUT_CYC = 16,
  parameter int unsigned REARM_DLY   = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           key_valid,
  input  logic [WIDTH-1:0]               key,
  input  logic                           relock,
  output logic                           ready,
  output logic                           unlock,
  output logic [$clog2(STEPS+1)-1:0]     step,
  output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt,
  output logic                           locked_out
);

  localparam int SW = $clog2(STEPS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int RW = $clog2(REARM_DLY + 1);

  localparam logic [SW-1:0] LAST    = SW'(STEPS - 1);
  localparam logic [FW-1:0] FMAX    = FW'(MAX_FAIL);
  localparam logic [RW-1:0] ARM_END = RW'(REARM_DLY - 1);

`ifdef SEQ_KEY_LOCK_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYC);

  typedef enum logic [1:0] {
    ARM, SEQ, OPEN, LOCKOUT
  } state_t;

  logic [LW-1:0] lock_cnt, lock_n;
`else
  typedef enum logic [1:0] {
    ARM, SEQ, OPEN
  } state_t;

  logic unused_lockout;
  assign unused_lockout = (LOCKOUT_CYC != 0);
`endif

  state_t        state, state_n;
  logic [SW-1:0] step_n;
  logic [FW-1:0] fail_n, fail_inc;
  logic [RW-1:0] arm_cnt, arm_n;
  logic          hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ARM;
      step     <= '0;
      fail_cnt <= '0;
      arm_cnt  <= '0;
`ifdef SEQ_KEY_LOCK_LOCKOUT_EN
      lock_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      step     <= step_n;
      fail_cnt <= fail_n;
      arm_cnt  <= arm_n;
`ifdef SEQ_KEY_LOCK_LOCKOUT_EN
      lock_cnt <= lock_n;
`endif
    end
  end

  // Masked compare against the pattern of the current step.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < STEPS; k++) begin
      if (step == SW'(k))
        hit = ((key ^ PATTERN[k*WIDTH +: WIDTH])
               & MASK[k*WIDTH +: WIDTH]) == '0;
    end
  end

  assign fail_inc = (fail_cnt == FMAX) ?
                    FMAX : fail_cnt + 1'b1;

  always_comb begin
    state_n = state;
    step_n  = step;
    fail_n  = fail_cnt;
    arm_n   = arm_cnt;
`ifdef SEQ_KEY_LOCK_LOCKOUT_EN
    lock_n  = lock_cnt;
`endif
    case (state)
      ARM: begin
        arm_n = arm_cnt + 1'b1;
        if (arm_cnt == ARM_END)
          state_n = SEQ;
      end
      SEQ: begin
        if (relock) begin
          step_n = '0;
        end else if (key_valid) begin
          if (hit) begin
            if (step == LAST) begin
              state_n = OPEN;
              step_n  = '0;
              fail_n  = '0;
            end else begin
              step_n = step + 1'b1;
            end
          end else begin
            step_n = '0;
            fail_n = fail_inc;
`ifdef SEQ_KEY_LOCK_LOCKOUT_EN
            if (fail_inc == FMAX) begin
              state_n = LOCKOUT;
              lock_n  = LOCK_LOAD;
            end
`endif
          end
        end
      end
      OPEN: begin
        if (relock)
          state_n = SEQ;
      end
`ifdef SEQ_KEY_LOCK_LOCKOUT_EN
      LOCKOUT: begin
        // Exit on the edge that consumes the last lockout cycle.
        lock_n = lock_cnt - 1'b1;
        if (lock_cnt == LW'(1)) begin
          state_n = SEQ;
          fail_n  = '0;
        end
      end
`endif
      default: state_n = ARM;
    endcase
  end

  assign ready  = (state == SEQ);
  assign unlock = (state == OPEN);
`ifdef SEQ_KEY_LOCK_LOCKOUT_EN
  assign locked_out = (state == LOCKOUT);
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_seq_key_lock.sv
// Bench for seq_key_lock: directed scenarios plus
// random stimulus against a behavioural model.
module tb_seq_key_lock;

  localparam int STEPS = 3;
  localparam int MAXF  = 3;
  localparam int LCYC  = 16;
  localparam int REARM = 2;
`ifdef SEQ_KEY_LOCK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       kv = 1'b0;
  logic [7:0] kd = 8'h00;
  logic       rl = 1'b0;
  logic       ready, unlock, locked_out;
  logic [1:0] step, fail_cnt;

  seq_key_lock dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_valid  (kv),
    .key        (kd),
    .relock     (rl),
    .ready      (ready),
    .unlock     (unlock),
    .step       (step),
    .fail_cnt   (fail_cnt),
    .locked_out (locked_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Behavioural model: per-step pattern/mask tables
  // and plain counters for the timed phases.
  byte unsigned pats [STEPS] = '{8'h84, 8'h3C, 8'h00};
  byte unsigned msks [STEPS] = '{8'hA5, 8'hFF, 8'h0F};

  bit m_arming  = 1'b1;
  int m_armed   = 0;
  bit m_open    = 1'b0;
  int m_lock    = 0;
  int m_idx     = 0;
  int m_fail    = 0;

  function automatic bit key_ok(int idx, byte unsigned k);
    return ((k ^ pats[idx]) & msks[idx]) == 0;
  endfunction

  task automatic model_edge();
    if (!rstn) begin
      m_arming = 1'b1;
      m_armed  = 0;
      m_open   = 1'b0;
      m_lock   = 0;
      m_idx    = 0;
      m_fail   = 0;
    end else if (m_arming) begin
      m_armed++;
      if (m_armed == REARM) m_arming = 1'b0;
    end else if (m_open) begin
      if (rl) m_open = 1'b0;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fail = 0;
    end else if (rl) begin
      m_idx = 0;
    end else if (kv) begin
      if (key_ok(m_idx, kd)) begin
        if (m_idx == STEPS - 1) begin
          m_open = 1'b1;
          m_idx  = 0;
          m_fail = 0;
        end else begin
          m_idx++;
        end
      end else begin
        m_idx = 0;
        if (m_fail < MAXF) m_fail++;
        if (LOCK_EN && m_fail == MAXF) m_lock = LCYC;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ready", int'(ready),
        int'(!m_arming && !m_open && m_lock == 0));
    chk("unlock", int'(unlock), int'(m_open));
    chk("step", int'(step), m_idx);
    chk("fail_cnt", int'(fail_cnt), m_fail);
    chk("locked_out", int'(locked_out), int'(m_lock > 0));
  endtask

  task automatic drive(bit r, bit v, byte unsigned k, bit l);
    rstn = r;
    kv   = v;
    kd   = k;
    rl   = l;
    tick();
  endtask

  task automatic good_seq();
    drive(1, 1, 8'h86, 0);
    drive(1, 1, 8'h3C, 0);
    drive(1, 1, 8'hF0, 0);
  endtask

  int n;
  byte unsigned rk;
  int ri;

  initial begin
    // Reset, key during ARM ignored, re-arm latency.
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    rstn = 1'b1;
    kv   = 1'b1;
    kd   = 8'h86;
    n    = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 10);
    chk("rearm_edges", n, REARM);
    chk("arm_key_step", int'(step), 0);

    // Full valid sequence.
    drive(1, 0, 8'h00, 0);
    good_seq();
    chk("s2_unlock", int'(unlock), 1);
    chk("s2_ready", int'(ready), 0);

    // Relock from OPEN.
    drive(1, 0, 8'h00, 1);
    chk("s5_unlock", int'(unlock), 0);
    chk("s5_ready", int'(ready), 1);

    // Mismatch at step 1, then recover.
    drive(1, 1, 8'h86, 0);
    drive(1, 1, 8'h3D, 0);
    chk("s3_fail", int'(fail_cnt), 1);
    good_seq();
    chk("s3_unlock", int'(unlock), 1);
    drive(1, 0, 8'h00, 1);

    // Lockout (or saturation without the feature).
    drive(1, 1, 8'h01, 0);
    drive(1, 1, 8'h01, 0);
    drive(1, 1, 8'h01, 0);
    chk("s4_fail", int'(fail_cnt), MAXF);
    n = 0;
    while (locked_out && n < 100) begin
      drive(1, 1, 8'h86, 0);
      n++;
    end
    chk("s4_lock_len", n, LOCK_EN ? LCYC : 0);
    chk("s4_ready", int'(ready), 1);
    chk("s4_fail_after", int'(fail_cnt),
        LOCK_EN ? 0 : MAXF);

    // Relock at step 2 with a matching key.
    drive(1, 1, 8'h86, 0);
    drive(1, 1, 8'h3C, 0);
    drive(1, 1, 8'hF0, 1);
    chk("s5_step", int'(step), 0);
    chk("s5b_unlock", int'(unlock), 0);

    // Reset mid-sequence.
    drive(1, 1, 8'h86, 0);
    drive(1, 1, 8'h3C, 0);
    drive(0, 0, 8'h00, 0);
    chk("s6_step", int'(step), 0);
    drive(1, 0, 8'h00, 0);
    chk("s6_ready0", int'(ready), 0);
    drive(1, 0, 8'h00, 0);
    chk("s6_ready1", int'(ready), 1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      ri = m_idx;
      if ($urandom_range(3) != 0)
        rk = byte'((pats[ri] & msks[ri]) |
                   ($urandom & ~msks[ri]));
      else
        rk = byte'($urandom);
      drive($urandom_range(299) != 0,
            $urandom_range(2) != 0,
            rk,
            $urandom_range(24) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
